// File: rtl/fixed_dwn_thermometer_pipe_if.sv
// Bundle of the feature stream, encoded output stream and threshold config port
// of the thermometer encoder. The master side drives features and config; the
// slave side is the encoder.
interface fixed_dwn_thermometer_pipe_if #(
  parameter int unsigned NUM_FEATURES   = 4,
  parameter int unsigned FEATURE_WIDTH  = 8,
  parameter int unsigned NUM_THRESHOLDS = 8,
  parameter int unsigned ADDR_WIDTH     = (NUM_FEATURES * NUM_THRESHOLDS > 1) ?
                                          $clog2(NUM_FEATURES * NUM_THRESHOLDS) : 1
);

  logic [NUM_FEATURES*FEATURE_WIDTH-1:0]  data_in_0;
  logic                                   data_in_0_valid;
  logic                                   data_in_0_ready;
  logic [NUM_FEATURES*NUM_THRESHOLDS-1:0] data_out_0;
  logic                                   data_out_0_valid;
  logic                                   data_out_0_ready;
  logic                                   cfg_valid;
  logic                                   cfg_ready;
  logic [ADDR_WIDTH-1:0]                  cfg_addr;
  logic [FEATURE_WIDTH-1:0]               cfg_data;
  logic                                   cfg_err;

  modport master (
    output data_in_0, data_in_0_valid, data_out_0_ready, cfg_valid, cfg_addr, cfg_data,
    input  data_in_0_ready, data_out_0, data_out_0_valid, cfg_ready, cfg_err
  );

  modport slave (
    input  data_in_0, data_in_0_valid, data_out_0_ready, cfg_valid, cfg_addr, cfg_data,
    output data_in_0_ready, data_out_0, data_out_0_valid, cfg_ready, cfg_err
  );

endinterface

// File: rtl/fixed_dwn_thermometer_pipe.sv
// Two-stage pipelined thermometer encoder for the DWN input layer. Each feature is
// compared against NUM_THRESHOLDS runtime-programmable thresholds; one output bit
// per (feature, threshold) pair. Thresholds may only be rewritten while the
// pipeline is empty, so every beat sees a consistent threshold set.
module fixed_dwn_thermometer_pipe #(
  parameter int unsigned NUM_FEATURES   = 4,
  parameter int unsigned FEATURE_WIDTH  = 8,
  parameter int unsigned NUM_THRESHOLDS = 8,
  parameter bit          SIGNED         = 1'b0,
  parameter logic [NUM_FEATURES*NUM_THRESHOLDS*FEATURE_WIDTH-1:0] INIT_THRESHOLDS = '0,
  parameter int unsigned ADDR_WIDTH     = (NUM_FEATURES * NUM_THRESHOLDS > 1) ?
                                          $clog2(NUM_FEATURES * NUM_THRESHOLDS) : 1
) (
  input logic                          clk,
  input logic                          rst_n,
  fixed_dwn_thermometer_pipe_if.slave  bus
);

  localparam int unsigned NumEntries = NUM_FEATURES * NUM_THRESHOLDS;
  localparam int unsigned InWidth    = NUM_FEATURES * FEATURE_WIDTH;

  logic [FEATURE_WIDTH-1:0] thresholds [NumEntries];

  logic                  s1_valid;
  logic [InWidth-1:0]    s1_data;
  logic                  out_valid;
  logic [NumEntries-1:0] out_data;
  logic [NumEntries-1:0] cmp;
  logic                  cfg_err;

  logic adv2;
  logic cfg_ready;
  logic cfg_fire;
  logic in_ready;
  logic in_fire;
  logic addr_ok;

  assign adv2      = !out_valid || bus.data_out_0_ready;
  assign cfg_ready = !s1_valid && !out_valid;
  assign cfg_fire  = bus.cfg_valid && cfg_ready;
  // A config write takes priority over a data beat in the same cycle.
  assign in_ready  = (!s1_valid || adv2) && !cfg_fire;
  assign in_fire   = bus.data_in_0_valid && in_ready;
  assign addr_ok   = 32'(bus.cfg_addr) < NumEntries;

  assign bus.data_in_0_ready  = in_ready;
  assign bus.cfg_ready        = cfg_ready;
  assign bus.cfg_err          = cfg_err;
  assign bus.data_out_0       = out_data;
  assign bus.data_out_0_valid = out_valid;

  // Threshold registers: reset image, overwritten by in-range config writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        thresholds[i] <= INIT_THRESHOLDS[i*FEATURE_WIDTH +: FEATURE_WIDTH];
      end
    end else if (cfg_fire && addr_ok) begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        if (32'(bus.cfg_addr) == i) begin
          thresholds[i] <= bus.cfg_data;
        end
      end
    end
  end

  // Sticky error for writes that address a non-existent threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (cfg_fire && !addr_ok) begin
      cfg_err <= 1'b1;
    end
  end

  // Stage 1: capture raw features; empties when its beat moves to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= bus.data_in_0;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // Compare every stage-1 feature against its thresholds; equality counts as set.
  always_comb begin
    cmp = '0;
    for (int unsigned f = 0; f < NUM_FEATURES; f++) begin
      for (int unsigned t = 0; t < NUM_THRESHOLDS; t++) begin
        if (SIGNED) begin
          cmp[f*NUM_THRESHOLDS+t] =
            $signed(s1_data[f*FEATURE_WIDTH +: FEATURE_WIDTH]) >=
            $signed(thresholds[f*NUM_THRESHOLDS+t]);
        end else begin
          cmp[f*NUM_THRESHOLDS+t] =
            s1_data[f*FEATURE_WIDTH +: FEATURE_WIDTH] >= thresholds[f*NUM_THRESHOLDS+t];
        end
      end
    end
  end

  // Stage 2: registered compare results, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= cmp;
      end
    end
  end

endmodule
